mybus_exec_arbiter: RTL
=======================

Name: mybus_exec_arbiter

Overview:
- Shares the single MyBus execute channel (execute1/dataTx1 toward the S3 stage) between NUM_REQ requesters.
- Uses round-robin with bounded bursts.
- Provides an isolation handshake: on isolation request it stops granting, drains the output stage, clamps outputs to 0, then acknowledges. Power control can then safely isolate the M1/M2 boundary.
- Sits between the requesting stage logic and the S3-facing bus registers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of dataTx1 and of each requester data word.
- MAX_BURST, 4, maximum accepted beats per grant before forced rotation (1..15).

Ports:
- ck  input  1  clock, all logic rising-edge.
- srst_n  input  1  reset, synchronous, active-low.
- req  input  NUM_REQ  per-requester request; held until its beats are done.
- req_data  input  NUM_REQ*DATA_W  requester i data in slice [i*DATA_W +: DATA_W].
- ready  input  1  downstream ready (MyBus ready); a beat is accepted only when high.
- isolate_req  input  1  isolation request (isolateM1M2 source).
- gnt  output  NUM_REQ  registered one-hot grant.
- execute1  output  1  registered beat strobe toward S3.
- dataTx1  output  DATA_W  registered beat data toward S3.
- isolate_ack  output  1  high while channel is drained and clamped.

Behaviour:
- Reset (srst_n=0 at a rising ck):
  - state=IDLE; gnt=0, execute1=0, dataTx1=0, isolate_ack=0.
  - Beat counter=0; RR pointer=0, so requester 0 has top priority first.
- Beat definition: beat = gnt[i] & req[i] & ready for the owner i. At most one beat per cycle.
- Output stage:
  - Next edge after any cycle: execute1 <= beat; dataTx1 <= beat ? req_data[owner] : 0.
  - Latency from accepted beat to execute1 is exactly 1 cycle.
  - dataTx1 is 0 whenever execute1 is 0.
- FSM states: IDLE, GRANT, DRAIN, ISOLATED.
  - IDLE, isolate_req=1 -> DRAIN. Isolation takes priority over requests.
  - IDLE, any req, isolate_req=0 -> GRANT.
    - Owner = first requester with req high, searching from rr_ptr upward with wrap-around.
    - gnt[owner]=1 on the next edge; beat counter=0.
    - Requests are seen at earliest 1 cycle after assertion, so gnt rises 1 edge after req is sampled in IDLE.
  - GRANT releases on the next edge, to IDLE, when any of the following holds:
    - req[owner]=0 (requester withdrew); or
    - beat this cycle with counter==MAX_BURST-1; or
    - isolate_req=1.
    - A beat occurring in the release cycle still counts and still produces execute1.
    - On release: gnt=0, rr_ptr = owner+1 mod NUM_REQ, counter=0.
    - Every release is followed by at least one IDLE cycle, so ownership never transfers gnt-to-gnt without a gap.
  - GRANT otherwise: hold gnt; counter increments on each beat.
    - ready=0 stalls without a timeout and without counting.
  - DRAIN: gnt=0; wait for execute1=0 (the last beat has left), then -> ISOLATED.
    - Minimum 1 cycle in DRAIN.
    - If isolate_req drops while in DRAIN -> IDLE, and isolate_ack never asserts.
  - ISOLATED: isolate_ack=1, gnt=0, execute1=0, dataTx1=0.
    - req and ready are ignored.
    - isolate_req=0 -> IDLE, and isolate_ack drops on that edge.
- Synchronous reset mid-burst or mid-isolation: everything returns to reset values on that edge.
  - An in-flight execute1 is dropped and no beat is generated.
- Simultaneous events:
  - release and new request in the same cycle: the new request is arbitrated only from IDLE.
  - isolate_req and a beat in the same cycle: the beat completes and isolation follows.
- Invariants:
  - gnt is one-hot or zero at all times.
  - isolate_ack=1 implies gnt=0 and execute1=0.

Test Plan:
- Reset: srst_n=0 for 2 cycles with req=4'b1111 -> gnt=0, execute1=0, dataTx1=0, isolate_ack=0. First grant after release of reset is gnt=4'b0001.
- Burst limit: req=4'b0001 held, ready=1, req_data[0]=8'hA5 -> execute1 high for exactly 4 consecutive cycles with dataTx1=8'hA5, then gnt=0 for 1 cycle, then gnt=4'b0001 again.
- Round-robin: req=4'b1011 held, ready=1 -> grant order 0,1,3,0,1,3, each grant delivering 4 beats.
- Backpressure: owner 2 granted, ready toggles 1,0,0,1,1,1 -> execute1 pulses only on the cycles after ready=1. Grant releases after the 4th accepted beat; no beats are lost or duplicated.
- Isolation mid-burst: isolate_req=1 after beat 2 of owner 1 -> beat in that cycle is delivered, then gnt=0, DRAIN, isolate_ack=1 within 3 cycles. With req=4'b1111 held, outputs stay 0. Dropping isolate_req gives isolate_ack=0 next edge and a grant resumes to owner 2.
- Withdrawal and reset: owner 0 drops req after 1 beat -> release next edge, rr_ptr=1. Separately, srst_n=0 during GRANT with ready=1 -> no execute1 on the following cycle.

Source files
------------

// File: rtl/mybus_exec_arbiter_if.sv
// MyBus execute-channel bundle between the requesting stage logic (master)
// and the execute arbiter (slave).
interface mybus_exec_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      ready;
    logic                      isolate_req;
    logic [NUM_REQ-1:0]        gnt;
    logic                      execute1;
    logic [DATA_W-1:0]         dataTx1;
    logic                      isolate_ack;

    modport master (
        output req, req_data, ready, isolate_req,
        input  gnt, execute1, dataTx1, isolate_ack
    );

    modport slave (
        input  req, req_data, ready, isolate_req,
        output gnt, execute1, dataTx1, isolate_ack
    );
endinterface

// File: rtl/mybus_exec_arbiter.sv
// Round-robin, burst-bounded arbiter for the MyBus execute channel toward S3,
// with an isolation handshake that drains and clamps the channel before acking.
module mybus_exec_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input logic                 ck,
    input logic                 srst_n,
    mybus_exec_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_ISOLATED = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_execute1;
    logic [DATA_W-1:0]  r_data;
    logic               r_ack;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [IDX_W-1:0]   w_rr_ptr_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic               w_ack_nxt;
    logic               w_release;
    logic               w_beat;
    logic [DATA_W-1:0]  w_beat_data;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W:0]     w_sum;
    logic [IDX_W-1:0]   w_idx;

    assign w_beat      = (r_state == ST_GRANT) & bus.req[r_owner] & bus.ready;
    assign w_beat_data = w_beat ? bus.req_data[int'(r_owner) * DATA_W +: DATA_W] : '0;

    // Round-robin pick: scan downward so the entry closest to r_rr_ptr wins.
    always_comb begin
        w_pick = r_rr_ptr;
        w_sum  = '0;
        w_idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sum  = {1'b0, r_rr_ptr} + (IDX_W + 1)'(i);
            w_sum  = (w_sum >= (IDX_W + 1)'(NUM_REQ)) ? w_sum - (IDX_W + 1)'(NUM_REQ) : w_sum;
            w_idx  = w_sum[IDX_W-1:0];
            w_pick = bus.req[w_idx] ? w_idx : w_pick;
        end
    end

    // Next-state logic: grant, bounded burst release and isolation sequencing.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_cnt_nxt    = r_cnt;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.isolate_req) begin
                    w_state_nxt = ST_DRAIN;
                end else if (|bus.req) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_pick;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                w_release = ~bus.req[r_owner]
                          | (w_beat & (r_cnt == CNT_W'(MAX_BURST - 1)))
                          | bus.isolate_req;
                if (w_release) begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = '0;
                    w_rr_ptr_nxt = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
                end else if (w_beat) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_DRAIN: begin
                // Wait until the last accepted beat has left the output stage.
                if (!bus.isolate_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (!r_execute1) begin
                    w_state_nxt = ST_ISOLATED;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_ISOLATED: begin
                if (!bus.isolate_req) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ISOLATED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_gnt_nxt = (w_state_nxt == ST_GRANT) ? (NUM_REQ'(1) << w_owner_nxt) : '0;
        w_ack_nxt = (w_state_nxt == ST_ISOLATED);
    end

    // State, grant and output-stage registers with synchronous reset.
    always_ff @(posedge ck) begin
        if (!srst_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_execute1 <= 1'b0;
            r_data     <= '0;
            r_ack      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gnt      <= w_gnt_nxt;
            r_execute1 <= w_beat;
            r_data     <= w_beat_data;
            r_ack      <= w_ack_nxt;
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.execute1    = r_execute1;
    assign bus.dataTx1     = r_data;
    assign bus.isolate_ack = r_ack;
endmodule
